rv_wb_arbiter: RTL
==================

// Module: rv_wb_arbiter
// PURPOSE
//  Registered Wishbone-classic arbiter sharing one bus master port between the core's instruction-fetch
//  port and its load/store port. It replaces fixed combinational data-priority muxing with a grant FSM:
//  - latched address/control for the whole cycle
//  - starvation guard for instruction fetch
//  - bus-timeout watchdog
//  Sits between rv_core and the system Wishbone interconnect inside the top-level wrapper.
// PARAMETERS
//  RESET_ADDR        32'h0000_0000  supplies upper address bits [31:IADDR_SPACE_BITS] for fetch addresses
//  IADDR_SPACE_BITS  16             width of instruction address from core
//  DATA_BURST_MAX    4              max consecutive data grants while fetch pending (>=1)
//  TIMEOUT_CYCLES    255            cycles without i_wb_ack before abort; 0 disables watchdog
// PORTS
//  i_clk           in   1   clock, all logic on rising edge
//  i_reset_n       in   1   asynchronous active-low reset
//  i_instr_req     in   1   fetch request, held until o_instr_ack
//  i_instr_addr    in   IADDR_SPACE_BITS  fetch address
//  o_instr_ack     out  1   fetch complete (one-cycle pulse)
//  o_instr_data    out  32  fetch data, valid with o_instr_ack
//  i_data_req      in   1   load/store request, held until o_data_ack
//  i_data_write    in   1   1=store
//  i_data_addr     in   32  load/store address
//  i_data_wdata    in   32  store data
//  i_data_sel      in   4   byte lanes
//  o_data_ack      out  1   load/store complete (one-cycle pulse)
//  o_data_rdata    out  32  load data, valid with o_data_ack
//  o_bus_err       out  1   one-cycle pulse with the ack of a timed-out transfer
//  o_wb_adr        out  32  Wishbone address
//  o_wb_dat        out  32  Wishbone write data
//  i_wb_dat        in   32  Wishbone read data
//  o_wb_we         out  1   write enable
//  o_wb_sel        out  4   byte select
//  o_wb_stb        out  1   strobe
//  o_wb_cyc        out  1   cycle
//  i_wb_ack        in   1   slave acknowledge
// BEHAVIOUR
//  Reset / outputs
//  - While i_reset_n=0 (async, also mid-transfer), everything is 0:
//    state=IDLE, streak/timeout counters, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat.
//  - Acks, o_bus_err and rdata outputs read 0.
//  - A transfer interrupted by reset is dropped, never acked.
//  FSM states
//  - IDLE: cyc=stb=0.
//    * Data is picked if i_data_req & (streak<DATA_BURST_MAX | !i_instr_req).
//    * Otherwise fetch is picked if i_instr_req.
//    * On the edge, latch adr/dat/we/sel and go to DATA or INSTR.
//  - INSTR: cyc=stb=1, we=0, sel=4'hF, adr={RESET_ADDR[31:IADDR_SPACE_BITS], latched i_instr_addr}.
//  - DATA: cyc=stb=1, with latched i_data_addr, i_data_wdata, i_data_write, i_data_sel.
//  - INSTR/DATA -> IDLE on i_wb_ack or timeout. Every transfer therefore ends with one IDLE cycle (cyc=0).
//  Latency and acks
//  - Request first seen in IDLE at cycle N -> cyc/stb high at N+1. Ack at earliest N+1.
//  - Back-to-back grant issued no earlier than N+3.
//  - o_instr_ack = (state==INSTR)&(i_wb_ack|tmo). o_data_ack likewise for DATA. Both combinational.
//  - o_instr_data / o_data_rdata = i_wb_dat while the matching ack is high, 0 otherwise.
//  Requester handshake
//  - Requesters hold req and payload stable until their ack.
//  - A changed payload after grant is ignored because it is latched.
//  - A req dropped before ack is a protocol violation; the transfer still completes.
//  Starvation counter
//  - streak (3-bit min, sized for DATA_BURST_MAX) is incremented on each DATA grant made while i_instr_req=1.
//  - Cleared on any INSTR grant, or on a DATA grant with i_instr_req=0.
//  - Saturates at DATA_BURST_MAX.
//  Watchdog
//  - Timeout counter is cleared on entering INSTR/DATA and counts each granted cycle without ack.
//  - tmo asserts when count==TIMEOUT_CYCLES-1 and i_wb_ack=0. That gives ack+o_bus_err=1 with rdata=0.
//  - If i_wb_ack and tmo coincide, the ack wins: o_bus_err=0 and data passes through.
//  - TIMEOUT_CYCLES=0: counter inactive, o_bus_err never asserts.
//  Simultaneous events
//  - Both reqs in IDLE: data wins unless streak==DATA_BURST_MAX.
//  - i_wb_ack seen in IDLE is ignored and produces no ack.
// TESTING
//  - Fetch only: instr_req, addr=16'h0100, ack after 2 cycles -> wb_adr=32'h0000_0100, sel=F, we=0.
//    o_instr_ack one pulse, data passed, cyc low the next cycle.
//  - Both req same cycle, store addr=32'h2000_0004, wdata=32'hDEADBEEF, sel=4'h3 -> data granted first.
//    o_wb_we=1 with latched values; fetch granted after IDLE cycle.
//  - Data req held continuously with fetch pending, DATA_BURST_MAX=4 -> grants D,D,D,D,I,D...
//    No 5th consecutive data grant.
//  - TIMEOUT_CYCLES=8, slave never acks -> 8th granted cycle gives ack+o_bus_err=1, rdata=0, state IDLE.
//    Ack exactly on cycle 8 -> no err.
//  - Reset asserted mid-DATA transfer -> cyc/stb/we/sel drop to 0 immediately.
//    No ack after release; pending req re-arbitrated.

Source files
------------

// File: rtl/rv_wb_arbiter.sv
// Wishbone-classic arbiter: shares one bus master port between instruction fetch and load/store,
// with latched per-cycle address/control, a fetch starvation guard and a bus-timeout watchdog.
module rv_wb_arbiter #(
  parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
  parameter int unsigned IADDR_SPACE_BITS = 16,
  parameter int unsigned DATA_BURST_MAX   = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_instr_req,
  input  logic [IADDR_SPACE_BITS-1:0] i_instr_addr,
  output logic                        o_instr_ack,
  output logic [31:0]                 o_instr_data,
  input  logic                        i_data_req,
  input  logic                        i_data_write,
  input  logic [31:0]                 i_data_addr,
  input  logic [31:0]                 i_data_wdata,
  input  logic [3:0]                  i_data_sel,
  output logic                        o_data_ack,
  output logic [31:0]                 o_data_rdata,
  output logic                        o_bus_err,
  output logic [31:0]                 o_wb_adr,
  output logic [31:0]                 o_wb_dat,
  input  logic [31:0]                 i_wb_dat,
  output logic                        o_wb_we,
  output logic [3:0]                  o_wb_sel,
  output logic                        o_wb_stb,
  output logic                        o_wb_cyc,
  input  logic                        i_wb_ack
);

  localparam int unsigned STREAK_W =
    ($clog2(DATA_BURST_MAX + 1) > 3) ? $clog2(DATA_BURST_MAX + 1) : 3;
  localparam int unsigned TMO_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_BURST_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic        TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] FETCH_MASK = 32'((64'd1 << IADDR_SPACE_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t              r_state;
  logic [STREAK_W-1:0] r_streak;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [31:0]         r_wb_adr;
  logic [31:0]         r_wb_dat;
  logic                r_wb_we;
  logic [3:0]          r_wb_sel;
  logic                r_wb_stb;
  logic                r_wb_cyc;

  logic                w_granted;
  logic                w_tmo;
  logic                w_done;
  logic                w_pick_data;
  logic                w_pick_instr;
  logic [31:0]         w_fetch_adr;
  logic [STREAK_W-1:0] w_streak_inc;

  assign w_granted    = (r_state != S_IDLE);
  assign w_tmo        = TMO_EN && w_granted && !i_wb_ack && (r_tmo_cnt == TMO_LAST);
  assign w_done       = w_granted && (i_wb_ack || w_tmo);
  // Data has priority unless fetch has been passed over DATA_BURST_MAX times in a row
  assign w_pick_data  = i_data_req && ((r_streak < STREAK_MAX) || !i_instr_req);
  assign w_pick_instr = !w_pick_data && i_instr_req;
  assign w_fetch_adr  = (RESET_ADDR & ~FETCH_MASK) | (32'(i_instr_addr) & FETCH_MASK);
  assign w_streak_inc = (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + STREAK_W'(1);

  // Completion is reported in the same cycle as the slave ack or the timeout
  assign o_instr_ack  = (r_state == S_INSTR) && (i_wb_ack || w_tmo);
  assign o_data_ack   = (r_state == S_DATA) && (i_wb_ack || w_tmo);
  assign o_instr_data = ((r_state == S_INSTR) && i_wb_ack) ? i_wb_dat : 32'h0;
  assign o_data_rdata = ((r_state == S_DATA) && i_wb_ack) ? i_wb_dat : 32'h0;
  assign o_bus_err    = w_tmo;

  assign o_wb_adr = r_wb_adr;
  assign o_wb_dat = r_wb_dat;
  assign o_wb_we  = r_wb_we;
  assign o_wb_sel = r_wb_sel;
  assign o_wb_stb = r_wb_stb;
  assign o_wb_cyc = r_wb_cyc;

  // Grant FSM with latched bus payload
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_streak  <= '0;
      r_tmo_cnt <= '0;
      r_wb_adr  <= '0;
      r_wb_dat  <= '0;
      r_wb_we   <= 1'b0;
      r_wb_sel  <= '0;
      r_wb_stb  <= 1'b0;
      r_wb_cyc  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_data) begin
            r_state   <= S_DATA;
            r_streak  <= i_instr_req ? w_streak_inc : '0;
            r_tmo_cnt <= '0;
            r_wb_adr  <= i_data_addr;
            r_wb_dat  <= i_data_wdata;
            r_wb_we   <= i_data_write;
            r_wb_sel  <= i_data_sel;
            r_wb_stb  <= 1'b1;
            r_wb_cyc  <= 1'b1;
          end else if (w_pick_instr) begin
            r_state   <= S_INSTR;
            r_streak  <= '0;
            r_tmo_cnt <= '0;
            r_wb_adr  <= w_fetch_adr;
            r_wb_we   <= 1'b0;
            r_wb_sel  <= 4'hF;
            r_wb_stb  <= 1'b1;
            r_wb_cyc  <= 1'b1;
          end
        end
        S_INSTR, S_DATA: begin
          if (w_done) begin
            r_state  <= S_IDLE;
            r_wb_we  <= 1'b0;
            r_wb_sel <= '0;
            r_wb_stb <= 1'b0;
            r_wb_cyc <= 1'b0;
          end else if (TMO_EN) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_wb_stb <= 1'b0;
          r_wb_cyc <= 1'b0;
        end
      endcase
    end
  end

endmodule
